// File: rtl/snn_noc_pkg.sv
// snn_noc_pkg: shared packet format for the 4x4 torus NoC.
//   64-bit packet = {dest[63:60], src[59:56], ptype[55:54], payload[53:0]}.
//   Provides the packet struct, field positions, node address map and the
//   decoded-entry struct stored by the receive NIC.
package snn_noc_pkg;

  localparam int PKT_W     = 64;
  localparam int PAYLOAD_W = 54;

  localparam int DEST_HI = 63, DEST_LO = 60;
  localparam int SRC_HI  = 59, SRC_LO  = 56;
  localparam int TYPE_HI = 55, TYPE_LO = 54;
  localparam int PAY_HI  = 53, PAY_LO  = 0;

  // Node address map
  localparam logic [3:0] ADDR_PE0  = 4'd0;
  localparam logic [3:0] ADDR_PE1  = 4'd1;
  localparam logic [3:0] ADDR_PE2  = 4'd2;
  localparam logic [3:0] ADDR_PE3  = 4'd3;
  localparam logic [3:0] ADDR_PE4  = 4'd4;
  localparam logic [3:0] ADDR_ADD0 = 4'd5;
  localparam logic [3:0] ADDR_ADD1 = 4'd6;
  localparam logic [3:0] ADDR_ADD2 = 4'd7;
  localparam logic [3:0] ADDR_ADD3 = 4'd8;
  localparam logic [3:0] ADDR_ADD4 = 4'd9;
  localparam logic [3:0] ADDR_ADD5 = 4'd10;
  localparam logic [3:0] ADDR_ADD6 = 4'd11;
  localparam logic [3:0] ADDR_MEM  = 4'd12;

  typedef enum logic [1:0] {IFMAP = 2'b00, FILTER = 2'b01, PSUM = 2'b10, SPIKE = 2'b11} pkt_type_e;

  typedef struct packed {
    logic [3:0]           dest;
    logic [3:0]           src;
    pkt_type_e            ptype;
    logic [PAYLOAD_W-1:0] payload;
  } noc_pkt_t;

  // What the receiver keeps once dest has been checked
  typedef struct packed {
    logic [3:0]           src;
    pkt_type_e            ptype;
    logic [PAYLOAD_W-1:0] payload;
  } rx_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT_LO} rx_state_e;

  function automatic rx_entry_t decode_pkt(input noc_pkt_t p);
    rx_entry_t e;
    e.src     = p.src;
    e.ptype   = p.ptype;
    e.payload = p.payload;
    return e;
  endfunction

endpackage

// File: rtl/nic_rx_fifo.sv
// nic_rx_fifo: synchronous FIFO with a registered head and valid/ready read.
//   clk, rst_n        clock, async active-low reset
//   push_i, din_i     write strobe/data (caller never pushes while full)
//   dout_o, valid_o   registered head entry and its valid
//   ready_i           consumer pop (ignored while valid_o=0)
//   full_o, count_o   occupancy == DEPTH, occupancy
// An entry written into an empty FIFO shows at the head one cycle after the
// write. Head data only changes on a pop or when it becomes valid.
module nic_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 60,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  head_q;
  logic [AW-1:0] wr_q, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          pop;

  assign pop  = vld_q & ready_i;
  assign rd_d = rd_q + AW'(pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push_i && pop) cnt_d = cnt_q - CW'(1);
  end

  // Head validity looks only at entries present before this edge, so a push
  // into an empty FIFO surfaces a cycle later via the registered head.
  assign vld_d = (cnt_q - CW'(pop)) != '0;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
    head_q <= mem_q[rd_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign dout_o  = head_q;
  assign valid_o = vld_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;

endmodule

// File: rtl/nic_rx.sv
// nic_rx: clocked receiver on the router's 64-bit 4-phase bundled-data output.
//   clk, rst_n              clock, async active-low reset
//   net_req/net_data/net_ack  4-phase channel from router (req is asynchronous)
//   pkt_valid/pkt_ready     valid/ready to the local consumer
//   pkt_src/type/payload    decoded head packet
//   fifo_full               decoded FIFO holds FIFO_DEPTH entries
//   drop_pulse              one cycle per misaddressed packet
// Optional: NIC_RX_STATS_EN adds saturating stat_rx_cnt / stat_drop_cnt.
module nic_rx
  import snn_noc_pkg::*;
#(
  parameter logic [3:0] NODE_ADDR  = 4'b0000,
  parameter int         FIFO_DEPTH = 4,
  parameter int         PAYLOAD_W  = snn_noc_pkg::PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 net_req,
  input  logic [63:0]          net_data,
  output logic                 net_ack,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [3:0]           pkt_src,
  output logic [1:0]           pkt_type,
  output logic [PAYLOAD_W-1:0] pkt_payload,
  output logic                 fifo_full,
  output logic                 drop_pulse
`ifdef NIC_RX_STATS_EN
  ,
  output logic [15:0]          stat_rx_cnt,
  output logic [15:0]          stat_drop_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          req_meta_q, req_s_q;
  rx_state_e     state_q;
  logic          ack_q, drop_q;
  noc_pkt_t      in_pkt;
  rx_entry_t     head;
  logic          addr_match, space_avail, push, drop_ev;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full_w;

  // Two-flop synchroniser; net_data is only looked at once req_s_q is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
    end else begin
      req_meta_q <= net_req;
      req_s_q    <= req_meta_q;
    end
  end

  assign in_pkt      = noc_pkt_t'(net_data);
  assign addr_match  = in_pkt.dest == NODE_ADDR;
  // Full check uses current occupancy, so a same-edge pop never frees a slot.
  assign space_avail = fifo_cnt < CW'(FIFO_DEPTH);
  assign push        = (state_q == S_IDLE) && req_s_q && addr_match && space_avail;
  assign drop_ev     = (state_q == S_IDLE) && req_s_q && !addr_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Matching packet with a full FIFO waits here with ack low: the
          // router is backpressured. Misaddressed packets are acked at once.
          if (req_s_q && (!addr_match || space_avail)) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            drop_q  <= !addr_match;
          end
        end
        S_ACK: begin
          if (!req_s_q) begin
            state_q <= S_WAIT_LO;
            ack_q   <= 1'b0;
          end
        end
        S_WAIT_LO: state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  nic_rx_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(rx_entry_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (decode_pkt(in_pkt)),
    .dout_o  (head),
    .valid_o (pkt_valid),
    .ready_i (pkt_ready),
    .full_o  (fifo_full_w),
    .count_o (fifo_cnt)
  );

  assign net_ack     = ack_q;
  assign drop_pulse  = drop_q;
  assign fifo_full   = fifo_full_w;
  assign pkt_src     = head.src;
  assign pkt_type    = head.ptype;
  assign pkt_payload = PAYLOAD_W'(head.payload);

`ifdef NIC_RX_STATS_EN
  logic [15:0] rx_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push && rx_cnt_q != 16'hFFFF)      rx_cnt_q   <= rx_cnt_q + 16'd1;
      if (drop_ev && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign stat_rx_cnt   = rx_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  logic unused_drop_ev;
  assign unused_drop_ev = drop_ev;
`endif

endmodule

// File: tb/tb_nic_rx.sv
// tb_nic_rx: directed, table-driven bench for nic_rx (NODE_ADDR=1, depth 4).
module tb_nic_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        net_req = 1'b0;
  logic [63:0] net_data = '0;
  logic        pkt_ready = 1'b0;
  logic        net_ack, pkt_valid, fifo_full, drop_pulse;
  logic [3:0]  pkt_src;
  logic [1:0]  pkt_type;
  logic [53:0] pkt_payload;
`ifdef NIC_RX_STATS_EN
  logic [15:0] stat_rx_cnt, stat_drop_cnt;
`endif

  nic_rx #(.NODE_ADDR(4'b0001), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .net_req     (net_req),
    .net_data    (net_data),
    .net_ack     (net_ack),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_src     (pkt_src),
    .pkt_type    (pkt_type),
    .pkt_payload (pkt_payload),
    .fifo_full   (fifo_full),
    .drop_pulse  (drop_pulse)
`ifdef NIC_RX_STATS_EN
    ,
    .stat_rx_cnt   (stat_rx_cnt),
    .stat_drop_cnt (stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int drops = 0;
  logic [59:0] rxq[$];

  // Anything seen valid&ready here is popped on the following rising edge.
  always @(negedge clk) begin
    if (drop_pulse) drops++;
    if (pkt_valid && pkt_ready) rxq.push_back({pkt_src, pkt_type, pkt_payload});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [3:0] d, input logic [3:0] s,
                                     input logic [1:0] t, input logic [53:0] p);
    return {d, s, t, p};
  endfunction

  task automatic req_up(input logic [63:0] d);
    @(posedge clk); #1;
    net_data = d;
    net_req  = 1'b1;
  endtask

  // Edges counted from the edge just before req was raised.
  task automatic wait_ack(input int max_wait, output int lat, output logic v_at_ack, output logic ok);
    lat = 0; ok = 1'b0; v_at_ack = 1'b0;
    while (!ok && lat < max_wait) begin
      @(posedge clk); #1;
      lat++;
      ok = net_ack;
      v_at_ack = pkt_valid;
    end
  endtask

  task automatic req_down(output int fl, output logic v_next, output logic ok);
    net_req = 1'b0;
    fl = 0; ok = 1'b0; v_next = 1'b0;
    while (!ok && fl < 8) begin
      @(posedge clk); #1;
      fl++;
      if (fl == 1) v_next = pkt_valid;
      ok = !net_ack;
    end
  endtask

  task automatic send(input logic [63:0] d, output int lat, output logic v3,
                      output logic ok, output int fl, output logic v4, output logic ok2);
    req_up(d);
    wait_ack(8, lat, v3, ok);
    req_down(fl, v4, ok2);
  endtask

  typedef struct {
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [1:0]  typ;
    logic [53:0] pay;
    logic        accept;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, fl, d0, nacks;
    logic v3, v4, ok, ok2;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, fl, d0, nacks;
    logic v3, v4, ok, ok2;

    vecs[0] = '{4'h1, 4'h3, 2'b01, 54'hABC, 1'b1};
    vecs[1] = '{4'h5, 4'h2, 2'b00, 54'h123, 1'b0};
    vecs[2] = '{4'h1, 4'hF, 2'b11, 54'h3F_FFFF_FFFF_FFFF, 1'b1};
    vecs[3] = '{4'h1, 4'h0, 2'b10, 54'h0, 1'b1};
    vecs[4] = '{4'h0, 4'h1, 2'b10, 54'h55, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", net_ack, 0);
    check("rst_valid", pkt_valid, 0);
    check("rst_full", fifo_full, 0);
    check("rst_drop", drop_pulse, 0);
    rst_n = 1'b1;

    // Single packets: accepted and misaddressed, FIFO empty before each
    for (int i = 0; i < 5; i++) begin
      d0 = drops;
      rxq.delete();
      pkt_ready = 1'b0;
      send(mk(vecs[i].dest, vecs[i].src, vecs[i].typ, vecs[i].pay), lat, v3, ok, fl, v4, ok2);
      check($sformatf("v%0d_acked", i), ok, 1);
      check($sformatf("v%0d_ack_lat", i), lat, 3);
      check($sformatf("v%0d_ack_fall", i), ok2, 1);
      check($sformatf("v%0d_ack_fall_lat", i), fl, 3);
      check($sformatf("v%0d_vld_at_ack", i), v3, 0);
      check($sformatf("v%0d_vld_next", i), v4, vecs[i].accept);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d_drops", i), drops - d0, vecs[i].accept ? 0 : 1);
      check($sformatf("v%0d_valid", i), pkt_valid, vecs[i].accept);
      if (vecs[i].accept) begin
        check($sformatf("v%0d_src", i), pkt_src, vecs[i].src);
        check($sformatf("v%0d_type", i), pkt_type, vecs[i].typ);
        check($sformatf("v%0d_payload", i), pkt_payload, vecs[i].pay);
        pkt_ready = 1'b1;
        @(posedge clk); #1;
        pkt_ready = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d_popped", i), pkt_valid, 0);
        check($sformatf("v%0d_rx_count", i), rxq.size(), 1);
      end
    end

    // Backpressure: 4 fill the FIFO, 5th waits with ack low
    rxq.delete();
    pkt_ready = 1'b0;
    d0 = drops;
    for (int i = 0; i < 4; i++) begin
      send(mk(4'h1, 4'h7, 2'b10, 54'h100 + 54'(i)), lat, v3, ok, fl, v4, ok2);
      check($sformatf("bp%0d_acked", i), ok, 1);
    end
    check("bp_full", fifo_full, 1);
    req_up(mk(4'h1, 4'h7, 2'b10, 54'h104));
    wait_ack(8, lat, v3, ok);
    check("bp_5th_held", ok, 0);
    check("bp_5th_ack_low", net_ack, 0);
    pkt_ready = 1'b1;
    @(posedge clk); #1;
    pkt_ready = 1'b0;
    wait_ack(8, lat, v3, ok);
    check("bp_5th_acked", ok, 1);
    req_down(fl, v4, ok2);
    check("bp_5th_ack_fall", ok2, 1);
    pkt_ready = 1'b1;
    for (int c = 0; c < 40 && rxq.size() < 5; c++) @(posedge clk);
    #1;
    check("bp_rx_count", rxq.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rxq.size()) check($sformatf("bp_order%0d", i), rxq[i][53:0], 54'h100 + 54'(i));
    check("bp_no_drops", drops - d0, 0);

    // Streaming with ready held high: 16 packets, pointers wrap 4 times
    rxq.delete();
    d0 = drops;
    nacks = 0;
    for (int i = 0; i < 16; i++) begin
      send(mk(4'h1, 4'h2, 2'b11, 54'(i)), lat, v3, ok, fl, v4, ok2);
      if (!ok || !ok2) nacks++;
    end
    repeat (6) @(posedge clk);
    #1;
    check("stream_handshakes", nacks, 0);
    check("stream_rx_count", rxq.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < rxq.size()) check($sformatf("stream_pay%0d", i), rxq[i], {4'h2, 2'b11, 54'(i)});
    check("stream_no_drops", drops - d0, 0);
    check("stream_empty", pkt_valid, 0);

    // Reset in the middle of a handshake
    rxq.delete();
    pkt_ready = 1'b0;
    req_up(mk(4'h1, 4'h4, 2'b00, 54'hAA));
    wait_ack(8, lat, v3, ok);
    check("mid_acked", ok, 1);
    @(posedge clk); #1;
    check("mid_valid_before", pkt_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", net_ack, 0);
    check("mid_rst_valid", pkt_valid, 0);
    net_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(mk(4'h1, 4'h6, 2'b01, 54'hBB), lat, v3, ok, fl, v4, ok2);
    check("post_rst_lat", lat, 3);
    check("post_rst_fall", ok2, 1);
    pkt_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("post_rst_pkt", rxq[0], {4'h6, 2'b01, 54'hBB});

`ifdef NIC_RX_STATS_EN
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stat_rst_rx", stat_rx_cnt, 0);
    check("stat_rst_drop", stat_drop_cnt, 0);
    rst_n = 1'b1;
    pkt_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      send(mk((i % 2 == 1) ? 4'h9 : 4'h1, 4'h3, 2'b00, 54'(i)), lat, v3, ok, fl, v4, ok2);
    repeat (3) @(posedge clk);
    #1;
    check("stat_rx_cnt", stat_rx_cnt, 3);
    check("stat_drop_cnt", stat_drop_cnt, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
